// File: rtl/disp_pkg.sv
// Shared definitions for the display-sharing arbiter: state encoding and
// display value width.
package disp_pkg;
  localparam int DISP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;
endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             any_req
);

  logic w_found;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    any_req    = |req;
    w_found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req[(int'(ptr) + k) % NREQ]) begin
        w_found                               = 1'b1;
        win_onehot[(int'(ptr) + k) % NREQ]    = 1'b1;
        win_idx                               = PTR_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared seven-segment display with a minimum
// dwell time and a one-cycle break-before-make gap between owners.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int          DWELL    = 5000000,
  parameter logic [15:0] IDLE_VAL = 16'h0000
) (
  input  logic                   clk5,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [DISP_W*NREQ-1:0] val,
  output logic [NREQ-1:0]        grant,
  output logic [DISP_W-1:0]      dispVal,
  output logic                   blank
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(DWELL);

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [DISP_W-1:0]  r_disp, w_disp_nxt;
  logic               r_blank, w_blank_nxt;

  logic [NREQ-1:0]    w_win_oh;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_any;
  logic [DISP_W-1:0]  w_win_val, w_own_val;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic               w_cnt_sat, w_own_req, w_others;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .win_onehot (w_win_oh),
    .win_idx    (w_win_idx),
    .any_req    (w_any)
  );

  always_comb begin
    w_win_val = '0;
    w_own_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win_idx == PTR_W'(i)) w_win_val = val[i*DISP_W +: DISP_W];
      if (r_owner   == PTR_W'(i)) w_own_val = val[i*DISP_W +: DISP_W];
    end
  end

  // r_grant is the owner's one-hot mask in HOLD, so it doubles as the req filter.
  assign w_cnt_sat = (r_cnt == CNT_W'(DWELL - 1));
  assign w_own_req = |(req & r_grant);
  assign w_others  = |(req & ~r_grant);
  assign w_ptr_inc = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_disp_nxt  = r_disp;
    w_blank_nxt = r_blank;
    case (r_state)
      ST_IDLE, ST_SWITCH: begin
        if (w_any) begin
          w_state_nxt = ST_HOLD;
          w_owner_nxt = w_win_idx;
          w_grant_nxt = w_win_oh;
          w_cnt_nxt   = '0;
          w_disp_nxt  = w_win_val;
          w_blank_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_disp_nxt  = IDLE_VAL;
          w_blank_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        w_disp_nxt = w_own_val;
        if (!w_own_req || (w_cnt_sat && w_others)) begin
          w_state_nxt = ST_SWITCH;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end else if (!w_cnt_sat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_disp_nxt  = IDLE_VAL;
        w_blank_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_disp  <= IDLE_VAL;
      r_blank <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_disp  <= w_disp_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign grant   = r_grant;
  assign dispVal = r_disp;
  assign blank   = r_blank;

endmodule
